sprite_blitter: RTL and testbench
=================================

Name: sprite_blitter

Overview:
- Producer side of the double-buffered frame buffer. Accepts sprite draw commands over a valid/ready handshake.
- For each command it reads sprite texels from a synchronous sprite ROM and writes encoded 5-bit pixels into the back buffer at one pixel per cycle.
- Transparent texels and off-screen texels are skipped.
- After the last command of a frame it waits for the buffer swap (VS falling edge), then re-opens for the next frame.

Parameters:
- FB_W, 24: frame width in pixels. fb_addr = x + y*FB_W.
- FB_H, 45: frame height in pixels.
- PIX_W, 5: encoded pixel width.
- TRANSPARENT, 5'h15: texel code that is never written.
- SPR_AW, 10: sprite ROM address width.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  synchronous, active-high.
- cmd_valid  in  1  draw command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_x  in  10  sprite left column.
- cmd_y  in  10  sprite top row.
- cmd_w  in  6  sprite width; 0 means empty.
- cmd_h  in  6  sprite height; 0 means empty.
- cmd_base  in  SPR_AW  ROM address of texel (0,0); the sprite is stored row-major.
- frame_end  in  1  one-cycle pulse marking the end of the frame's command list.
- VS  in  1  vertical sync, active-low.
- rom_addr  out  SPR_AW  sprite ROM read address.
- rom_data  in  PIX_W  ROM data, valid 1 cycle after rom_addr.
- fb_we  out  1  back-buffer write enable.
- fb_addr  out  11  back-buffer address.
- fb_data  out  PIX_W  pixel to write.
- busy  out  1  high in any state other than IDLE.
- swap_done  out  1  one-cycle pulse when the swap is observed.

Behaviour:
- Reset, synchronous:
  - State goes to IDLE.
  - cmd_ready=0 during the Reset cycle and 1 afterwards.
  - fb_we=0, fb_addr=0, fb_data=0, rom_addr=0, busy=0, swap_done=0.
  - Pending frame_end flag cleared; VS history register set to 1.
- Reset asserted mid-command or mid-wait aborts immediately. No further fb_we until a new command is accepted.
- States: IDLE, FETCH, DRAIN, WAIT_SWAP.
- IDLE:
  - cmd_ready=1 unless the frame_end pending flag is set.
  - On accept: latch x, y, w, h, base. Clear col/row counters.
  - If w==0 or h==0, stay in IDLE (no ROM reads, no writes). Otherwise go to FETCH.
- FETCH:
  - Each cycle rom_addr = base + row*w + col, truncated to SPR_AW bits (wraps).
  - col increments. At col==w-1, col resets to 0 and row increments.
  - After issuing (w-1, h-1), go to DRAIN.
- Write pipeline:
  - Per-texel screen coords (x+col, y+row) and a valid bit are registered alongside the ROM read.
  - The cycle after each ROM read: fb_we=1 only if valid && rom_data!=TRANSPARENT && x+col<FB_W && y+row<FB_H.
  - On a write, fb_addr = (x+col) + (y+row)*FB_W, 11 bits, and fb_data = rom_data.
  - Coordinate arithmetic is 11 bits so no overflow occurs before the clip compare.
- DRAIN: emits the final pipelined write, then goes to IDLE, or to WAIT_SWAP if the pending flag is set.
- Latency and throughput:
  - Accept at cycle T gives the first rom_addr at T+1 and the first possible fb_we at T+2.
  - One pixel per cycle; a w*h sprite occupies FETCH for w*h cycles.
- frame_end:
  - Sets the pending flag in any state.
  - In IDLE with no command in flight, go to WAIT_SWAP next cycle.
  - frame_end in the same cycle as a command accept: the command is drawn first, then WAIT_SWAP.
- WAIT_SWAP:
  - cmd_ready=0 and fb_we=0.
  - On a VS falling edge (registered VS==1, current VS==0): pulse swap_done, clear the pending flag, go to IDLE.
  - VS held low on entry does not count; a fresh 1->0 edge is required.
- fb_we is never asserted outside the cycle after a valid ROM read.

Decomposition:
- Package fb_pkg:
  - FB_W, FB_H, PIX_W, TRANSPARENT constants.
  - Blitter state enum typedef.
  - fb_addr_t typedef (11 bits).
  - pixel_t typedef (5 bits).
- One sub-module, blit_addr_gen: col/row counters, ROM address computation, done flag.
- Clip, transparency and write stages stay in the top module.

Test Plan:
- 2x2 sprite, ROM[0..3]=1,2,3,4, cmd (0,0,w=2,h=2,base=0) accepted at T -> fb_we at T+2..T+5 with (addr,data) = (0,1),(1,2),(24,3),(25,4); busy low at T+6.
- Same sprite with ROM[1]=5'h15 -> exactly 3 writes, to addresses 0, 24, 25; no fb_we at T+3.
- Clip: 2x2 at (23,44), base 0 -> exactly one write, addr 1079 data 1; ROM reads still issued for all 4 texels.
- Zero size: cmd w=0,h=3 -> accepted, cmd_ready stays 1, no rom_addr change, no fb_we, busy never asserted.
- Swap: frame_end pulse while drawing a 2x2 -> drawing completes, then WAIT_SWAP with cmd_ready=0; with VS already 0, no swap_done; VS 0->1->0 -> swap_done pulse 1 cycle after the edge, cmd_ready=1 next cycle.
- Reset mid-op: 4x4 sprite, Reset asserted at T+4 -> cycle after Reset: fb_we=0, busy=0, cmd_ready=1; the next command draws from its own (0,0) texel.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared frame-buffer types and constants for the sprite blitter slice.
// Holds frame geometry, pixel encoding, the transparent texel code and
// the blitter state enumeration.
package fb_pkg;

    localparam int unsigned FB_W   = 24;   // frame width in pixels
    localparam int unsigned FB_H   = 45;   // frame height in pixels
    localparam int unsigned PIX_W  = 5;    // encoded pixel width
    localparam int unsigned SPR_AW = 10;   // sprite ROM address width
    localparam int unsigned FB_AW  = 11;   // frame-buffer address width
    localparam int unsigned CRD_W  = 10;   // command coordinate width
    localparam int unsigned DIM_W  = 6;    // sprite dimension width

    localparam logic [PIX_W-1:0] TRANSPARENT = 5'h15;

    typedef logic [FB_AW-1:0] fb_addr_t;
    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_FETCH     = 2'd1,
        S_DRAIN     = 2'd2,
        S_WAIT_SWAP = 2'd3
    } blit_state_t;

endpackage

// File: rtl/blit_addr_gen.sv
// Sprite texel walker: row-major col/row counters and ROM address.
// Ports:
//   Clk, Reset    clock, synchronous active-high reset
//   i_start       load base/size and point at texel (0,0)
//   i_step        advance to the next texel
//   i_base        ROM address of texel (0,0)
//   i_w, i_h      sprite size (non-zero when i_start is high)
//   o_rom_addr    registered ROM read address for the current texel
//   o_col, o_row  current texel coordinates within the sprite
//   o_last        current texel is (w-1, h-1)
module blit_addr_gen
    import fb_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              i_start,
    input  logic              i_step,
    input  logic [SPR_AW-1:0] i_base,
    input  logic [DIM_W-1:0]  i_w,
    input  logic [DIM_W-1:0]  i_h,
    output logic [SPR_AW-1:0] o_rom_addr,
    output logic [DIM_W-1:0]  o_col,
    output logic [DIM_W-1:0]  o_row,
    output logic              o_last
);

    logic [DIM_W-1:0]  r_w;
    logic [DIM_W-1:0]  r_h;
    logic [DIM_W-1:0]  r_col;
    logic [DIM_W-1:0]  r_row;
    logic [SPR_AW-1:0] r_row_base;
    logic [SPR_AW-1:0] r_addr;
    logic              w_row_end;

    assign w_row_end = (r_col == r_w - DIM_W'(1));

    // Row base accumulates base + row*w so no multiplier is needed; the
    // SPR_AW-bit adders give the required address wrap.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_w        <= '0;
            r_h        <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_row_base <= '0;
            r_addr     <= '0;
        end else if (i_start) begin
            r_w        <= i_w;
            r_h        <= i_h;
            r_col      <= '0;
            r_row      <= '0;
            r_row_base <= i_base;
            r_addr     <= i_base;
        end else if (i_step) begin
            if (w_row_end) begin
                r_col      <= '0;
                r_row      <= r_row + DIM_W'(1);
                r_row_base <= r_row_base + SPR_AW'(r_w);
                r_addr     <= r_row_base + SPR_AW'(r_w);
            end else begin
                r_col  <= r_col + DIM_W'(1);
                r_addr <= r_addr + SPR_AW'(1);
            end
        end
    end

    assign o_rom_addr = r_addr;
    assign o_col      = r_col;
    assign o_row      = r_row;
    assign o_last     = w_row_end && (r_row == r_h - DIM_W'(1));

endmodule

// File: rtl/sprite_blitter.sv
// Sprite blitter: draws sprite commands from a synchronous ROM into the
// back buffer at one pixel per cycle, skipping transparent and off-screen
// texels, and parks after the frame's last command until the VS swap.
// Ports:
//   Clk, Reset            clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_x, cmd_y          sprite top-left screen position
//   cmd_w, cmd_h          sprite size (0 = empty)
//   cmd_base              ROM address of texel (0,0)
//   frame_end             end-of-frame pulse
//   VS                    vertical sync, active-low
//   rom_addr, rom_data    sprite ROM port (1-cycle read latency)
//   fb_we/addr/data       back-buffer write port
//   busy                  not IDLE
//   swap_done             one-cycle pulse after the swap edge
module sprite_blitter
    import fb_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [9:0]        cmd_x,
    input  logic [9:0]        cmd_y,
    input  logic [5:0]        cmd_w,
    input  logic [5:0]        cmd_h,
    input  logic [SPR_AW-1:0] cmd_base,
    input  logic              frame_end,
    input  logic              VS,
    output logic [SPR_AW-1:0] rom_addr,
    input  logic [PIX_W-1:0]  rom_data,
    output logic              fb_we,
    output logic [10:0]       fb_addr,
    output logic [PIX_W-1:0]  fb_data,
    output logic              busy,
    output logic              swap_done
);

    blit_state_t      r_state;
    blit_state_t      w_next;
    logic [CRD_W-1:0] r_x;
    logic [CRD_W-1:0] r_y;
    logic             r_pend;
    logic             r_vs;
    logic             r_valid;
    logic             r_inb;
    fb_addr_t         r_fb_addr;
    logic             r_swap_done;

    logic             w_accept;
    logic             w_start;
    logic             w_step;
    logic             w_last;
    logic             w_vs_fall;
    logic             w_swap;
    logic [DIM_W-1:0] w_col;
    logic [DIM_W-1:0] w_row;
    fb_addr_t         w_px;
    fb_addr_t         w_py;
    pixel_t           w_pix;

    assign cmd_ready = (r_state == S_IDLE) && !r_pend && !Reset;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_start   = w_accept && (cmd_w != '0) && (cmd_h != '0);
    assign w_step    = (r_state == S_FETCH) && !w_last;
    assign w_vs_fall = r_vs && !VS;
    assign w_swap    = (r_state == S_WAIT_SWAP) && w_vs_fall;

    blit_addr_gen u_addr_gen (
        .Clk        (Clk),
        .Reset      (Reset),
        .i_start    (w_start),
        .i_step     (w_step),
        .i_base     (cmd_base),
        .i_w        (cmd_w),
        .i_h        (cmd_h),
        .o_rom_addr (rom_addr),
        .o_col      (w_col),
        .o_row      (w_row),
        .o_last     (w_last)
    );

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic; a zero-size accept never leaves IDLE
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start)                 w_next = S_FETCH;
                else if (frame_end || r_pend) w_next = S_WAIT_SWAP;
            end
            S_FETCH: begin
                if (w_last) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (frame_end || r_pend) w_next = S_WAIT_SWAP;
                else                     w_next = S_IDLE;
            end
            S_WAIT_SWAP: begin
                if (w_vs_fall) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // 11-bit screen coordinates of the texel being read this cycle
    assign w_px = FB_AW'(r_x) + FB_AW'(w_col);
    assign w_py = FB_AW'(r_y) + FB_AW'(w_row);

    // Write pipeline stage aligned with the ROM read, plus frame/swap flags
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_x         <= '0;
            r_y         <= '0;
            r_pend      <= 1'b0;
            r_vs        <= 1'b1;
            r_valid     <= 1'b0;
            r_inb       <= 1'b0;
            r_fb_addr   <= '0;
            r_swap_done <= 1'b0;
        end else begin
            r_vs        <= VS;
            r_swap_done <= w_swap;
            r_valid     <= (r_state == S_FETCH);
            if (w_start) begin
                r_x <= cmd_x;
                r_y <= cmd_y;
            end
            if (r_state == S_FETCH) begin
                r_inb     <= (w_px < FB_AW'(FB_W)) && (w_py < FB_AW'(FB_H));
                r_fb_addr <= w_px + w_py * FB_AW'(FB_W);
            end
            // A new frame_end outranks the clear so it is never lost
            if (frame_end)   r_pend <= 1'b1;
            else if (w_swap) r_pend <= 1'b0;
        end
    end

    // ROM data arrives the cycle after the read, so the write qualifier
    // is formed from it directly; Reset forces the write port idle.
    assign w_pix     = rom_data;
    assign fb_we     = r_valid && r_inb && (w_pix != TRANSPARENT) && !Reset;
    assign fb_data   = fb_we ? w_pix : '0;
    assign fb_addr   = r_fb_addr;
    assign busy      = (r_state != S_IDLE);
    assign swap_done = r_swap_done;

endmodule

// File: tb/tb_sprite_blitter.sv
module tb_sprite_blitter;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [9:0]  cmd_x = '0;
    logic [9:0]  cmd_y = '0;
    logic [5:0]  cmd_w = '0;
    logic [5:0]  cmd_h = '0;
    logic [9:0]  cmd_base = '0;
    logic        frame_end = 1'b0;
    logic        VS = 1'b1;
    logic [9:0]  rom_addr;
    logic [4:0]  rom_data;
    logic        fb_we;
    logic [10:0] fb_addr;
    logic [4:0]  fb_data;
    logic        busy;
    logic        swap_done;

    sprite_blitter dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_x     (cmd_x),
        .cmd_y     (cmd_y),
        .cmd_w     (cmd_w),
        .cmd_h     (cmd_h),
        .cmd_base  (cmd_base),
        .frame_end (frame_end),
        .VS        (VS),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .fb_we     (fb_we),
        .fb_addr   (fb_addr),
        .fb_data   (fb_data),
        .busy      (busy),
        .swap_done (swap_done)
    );

    always #5 Clk = ~Clk;

    // Sprite ROM with one cycle of read latency
    logic [4:0] rom [1024];
    always @(posedge Clk) rom_data <= rom[rom_addr];

    int cyc = 0;
    always @(posedge Clk) cyc = cyc + 1;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    typedef struct packed {
        logic [10:0] a;
        logic [4:0]  d;
    } wr_t;
    typedef struct {
        int c;
        int a;
        int d;
    } wl_t;

    wr_t        exp_fb  [int];
    logic [9:0] exp_rom [int];
    wl_t        wlog [$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    // Model: every texel of a sprite, in row-major order, is read one cycle
    // after the previous one starting at T+1 and written the following cycle
    // unless it is transparent or off-screen.
    task automatic model_cmd(input int t, input int x, input int y, input int w,
                             input int h, input int base);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                int k, a, px, py;
                logic [4:0] tex;
                k   = r * w + c;
                a   = (base + r * w + c) % 1024;
                tex = rom[a];
                px  = x + c;
                py  = y + r;
                exp_rom[t + 1 + k] = 10'(a);
                if (tex != 5'h15 && px < 24 && py < 45)
                    exp_fb[t + 2 + k] = '{a: 11'(px + py * 24), d: tex};
            end
        end
    endtask

    // Reset abandons everything the model still had scheduled
    task automatic model_abort(input int fb_from, input int rom_from);
        int keys [$];
        foreach (exp_fb[k]) if (k >= fb_from) keys.push_back(k);
        foreach (keys[i]) exp_fb.delete(keys[i]);
        keys.delete();
        foreach (exp_rom[k]) if (k >= rom_from) keys.push_back(k);
        foreach (keys[i]) exp_rom.delete(keys[i]);
    endtask

    // Per-cycle compare against the model
    always @(negedge Clk) begin
        if (chk_en) begin
            bit e;
            e = exp_fb.exists(cyc);
            checks++;
            if (fb_we !== e) begin
                errors++;
                $display("FAIL fb_we @cyc %0d: got %b expected %b", cyc, fb_we, e);
            end else if (e) begin
                checks++;
                if (fb_addr !== exp_fb[cyc].a || fb_data !== exp_fb[cyc].d) begin
                    errors++;
                    $display("FAIL fb_write @cyc %0d: got addr %0d data %0h expected addr %0d data %0h",
                             cyc, fb_addr, fb_data, exp_fb[cyc].a, exp_fb[cyc].d);
                end
            end
            if (fb_we === 1'b1) wlog.push_back('{c: cyc, a: int'(fb_addr), d: int'(fb_data)});
            if (exp_rom.exists(cyc)) begin
                checks++;
                if (rom_addr !== exp_rom[cyc]) begin
                    errors++;
                    $display("FAIL rom_addr @cyc %0d: got %0d expected %0d", cyc, rom_addr, exp_rom[cyc]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Present one command in the current cycle; returns the accept cycle
    task automatic send_cmd(input int x, input int y, input int w, input int h,
                            input int base, output int t);
        cmd_valid = 1'b1;
        cmd_x     = 10'(x);
        cmd_y     = 10'(y);
        cmd_w     = 6'(w);
        cmd_h     = 6'(h);
        cmd_base  = 10'(base);
        #1;
        check("cmd_ready_at_accept", 32'(cmd_ready), 32'd1);
        t = cyc;
        model_cmd(t, x, y, w, h, base);
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        int t, e;
        foreach (rom[i]) rom[i] = 5'd0;
        rom[0] = 5'd1; rom[1] = 5'd2; rom[2] = 5'd3; rom[3] = 5'd4;
        for (int i = 0; i < 16; i++) rom[100 + i] = 5'(i % 20 + 1);
        rom[200] = 5'd9; rom[201] = 5'd10;

        // Reset
        tick(); tick();
        check("ready_in_reset", 32'(cmd_ready), 32'd0);
        Reset = 1'b0;
        #1;
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fb_we", 32'(fb_we), 32'd0);
        check("rst_fb_addr", 32'(fb_addr), 32'd0);
        check("rst_fb_data", 32'(fb_data), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_swap_done", 32'(swap_done), 32'd0);
        chk_en = 1'b1;

        // 2x2 basic draw
        wlog.delete();
        send_cmd(0, 0, 2, 2, 0, t);
        while (cyc < t + 5) tick();
        check("t1_busy_T5", 32'(busy), 32'd1);
        tick();
        check("t1_busy_T6", 32'(busy), 32'd0);
        check("t1_nwrites", 32'(wlog.size()), 32'd4);
        if (wlog.size() == 4) begin
            check("t1_w0", 32'(wlog[0].a * 256 + wlog[0].d), 32'(0 * 256 + 1));
            check("t1_w1", 32'(wlog[1].a * 256 + wlog[1].d), 32'(1 * 256 + 2));
            check("t1_w2", 32'(wlog[2].a * 256 + wlog[2].d), 32'(24 * 256 + 3));
            check("t1_w3", 32'(wlog[3].a * 256 + wlog[3].d), 32'(25 * 256 + 4));
            check("t1_first_cyc", 32'(wlog[0].c - t), 32'd2);
            check("t1_last_cyc", 32'(wlog[3].c - t), 32'd5);
        end

        // Transparent texel
        rom[1] = 5'h15;
        wlog.delete();
        send_cmd(0, 0, 2, 2, 0, t);
        while (cyc < t + 6) tick();
        check("t2_nwrites", 32'(wlog.size()), 32'd3);
        if (wlog.size() == 3) begin
            check("t2_a0", 32'(wlog[0].a), 32'd0);
            check("t2_a1", 32'(wlog[1].a), 32'd24);
            check("t2_a2", 32'(wlog[2].a), 32'd25);
            check("t2_gap", 32'(wlog[1].c - t), 32'd4);
        end
        rom[1] = 5'd2;

        // Clip at the bottom-right corner
        wlog.delete();
        send_cmd(23, 44, 2, 2, 0, t);
        while (cyc < t + 4) tick();
        check("t3_rom_addr_T4", 32'(rom_addr), 32'd3);
        while (cyc < t + 6) tick();
        check("t3_nwrites", 32'(wlog.size()), 32'd1);
        if (wlog.size() == 1) begin
            check("t3_addr", 32'(wlog[0].a), 32'd1079);
            check("t3_data", 32'(wlog[0].d), 32'd1);
        end

        // Zero-size command
        wlog.delete();
        send_cmd(5, 5, 0, 3, 7, t);
        for (int i = 0; i < 4; i++) begin
            check("t4_ready", 32'(cmd_ready), 32'd1);
            check("t4_busy", 32'(busy), 32'd0);
            check("t4_rom_addr", 32'(rom_addr), 32'd3);
            tick();
        end
        check("t4_nwrites", 32'(wlog.size()), 32'd0);

        // frame_end during a draw, then VS swap
        wlog.delete();
        send_cmd(0, 0, 2, 2, 0, t);
        VS = 1'b0;
        tick();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        while (cyc < t + 6) tick();
        check("t5_busy_wait", 32'(busy), 32'd1);
        check("t5_ready_wait", 32'(cmd_ready), 32'd0);
        check("t5_nwrites", 32'(wlog.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("t5_no_swap_low", 32'(swap_done), 32'd0);
            check("t5_ready_low", 32'(cmd_ready), 32'd0);
            tick();
        end
        VS = 1'b1;
        tick(); tick();
        VS = 1'b0;
        e = cyc;
        check("t5_swap_at_edge", 32'(swap_done), 32'd0);
        tick();
        check("t5_swap_pulse", 32'(swap_done), 32'd1);
        check("t5_swap_cyc", 32'(cyc - e), 32'd1);
        check("t5_ready_after", 32'(cmd_ready), 32'd1);
        check("t5_busy_after", 32'(busy), 32'd0);
        tick();
        check("t5_swap_one_cycle", 32'(swap_done), 32'd0);
        VS = 1'b1;
        tick();

        // Reset in the middle of a 4x4 draw
        wlog.delete();
        send_cmd(0, 0, 4, 4, 100, t);
        while (cyc < t + 4) tick();
        Reset = 1'b1;
        model_abort(t + 4, t + 5);
        tick();
        Reset = 1'b0;
        #1;
        check("t6_fb_we", 32'(fb_we), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_ready", 32'(cmd_ready), 32'd1);
        check("t6_nwrites_abort", 32'(wlog.size()), 32'd2);
        wlog.delete();
        send_cmd(3, 1, 2, 1, 200, t);
        check("t6_new_rom_addr", 32'(rom_addr), 32'd200);
        while (cyc < t + 6) tick();
        check("t6_nwrites_new", 32'(wlog.size()), 32'd2);
        if (wlog.size() == 2) begin
            check("t6_w0", 32'(wlog[0].a * 256 + wlog[0].d), 32'(27 * 256 + 9));
            check("t6_w1", 32'(wlog[1].a * 256 + wlog[1].d), 32'(28 * 256 + 10));
        end

        tick(); tick();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
